ipv4_decoder: RTL and testbench

IPV4_DECODER -- requirements
Module: ipv4_decoder

---
 rtl/ipv4_decoder_pkg.sv | 25 ++
 rtl/ipv4_decoder_if.sv | 36 +++
 rtl/ipv4_hdr_checksum.sv | 26 ++
 rtl/ipv4_decoder.sv | 139 +++++++++++++
 tb/tb_ipv4_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ipv4_decoder_pkg.sv
// Shared types and constants for the IPv4 header decoder.
package ipv4_decoder_pkg;

   typedef enum logic [3:0] {
      IDLE, HDR_1, HDR_2, HDR_3, HDR_4, HDR_5, OPTION, PAYLOAD, FIN
   } state_e;

   localparam logic [3:0] IPV4_VERSION = 4'd4;
   localparam logic [3:0] IHL_MIN      = 4'd5;

   localparam logic [7:0] PROTO_ICMP = 8'd1;
   localparam logic [7:0] PROTO_TCP  = 8'd6;
   localparam logic [7:0] PROTO_UDP  = 8'd17;

   // One's-complement add of three halfwords with the end-around carry folded twice.
   function automatic logic [15:0] ones_add3(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c);
      logic [17:0] t;
      logic [16:0] u;
      t = {2'b00, a} + {2'b00, b} + {2'b00, c};
      u = {1'b0, t[15:0]} + {15'd0, t[17:16]};
      return u[15:0] + {15'd0, u[16]};
   endfunction

endpackage

// File: rtl/ipv4_decoder_if.sv
// Word-stream input and decoded-field outputs of the IPv4 decoder.
interface ipv4_decoder_if;
   logic [31:0] data;
   logic        start;
   logic [3:0]  version;
   logic [3:0]  ihl;
   logic [15:0] total_len;
   logic [15:0] ident;
   logic [2:0]  flags;
   logic [12:0] frag_off;
   logic [7:0]  ttl;
   logic [7:0]  protocol;
   logic [31:0] src_ip;
   logic [31:0] dest_ip;
   logic [15:0] len_payload;
   logic [31:0] payload_data;
   logic        payload_valid;
   logic        payload_start;
   logic        hdr_err;
   logic        fin;
   logic        ok;

   modport master (
      output data, start,
      input  version, ihl, total_len, ident, flags, frag_off, ttl, protocol,
             src_ip, dest_ip, len_payload, payload_data, payload_valid,
             payload_start, hdr_err, fin, ok
   );

   modport slave (
      input  data, start,
      output version, ihl, total_len, ident, flags, frag_off, ttl, protocol,
             src_ip, dest_ip, len_payload, payload_data, payload_valid,
             payload_start, hdr_err, fin, ok
   );
endinterface

// File: rtl/ipv4_hdr_checksum.sv
// Enable-gated one's-complement accumulator over 32-bit words.
module ipv4_hdr_checksum
   import ipv4_decoder_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] word_i,
   output logic [15:0] sum_o
);

   logic [15:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (en_i) sum_d = ones_add3(sum_q, word_i[31:16], word_i[15:0]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/ipv4_decoder.sv
// IPv4 header decoder: captures header fields, checks the checksum and streams the payload.
module ipv4_decoder
   import ipv4_decoder_pkg::*;
#(
   parameter bit DROP_FRAG = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   ipv4_decoder_if.slave  bus
);

   state_e      state_q, state_d;
   logic [3:0]  version_q, ihl_q;
   logic [15:0] total_len_q, ident_q, len_payload_q;
   logic [2:0]  flags_q;
   logic [12:0] frag_off_q;
   logic [7:0]  ttl_q, protocol_q;
   logic [31:0] src_ip_q, dest_ip_q, payload_data_q;
   logic        payload_valid_q, payload_start_q, hdr_err_q, fin_q, ok_q;
   logic [3:0]  opt_cnt_q;
   logic [15:0] pay_cnt_q;

   logic [15:0] csum;
   logic        csum_en, hdr_bad, err_now, fragmented, ok_d;

   assign hdr_bad = (version_q != IPV4_VERSION) || (ihl_q < IHL_MIN) ||
                    (total_len_q < {10'd0, ihl_q, 2'b00});
   assign err_now    = hdr_err_q || ((state_q == HDR_1) && hdr_bad);
   assign fragmented = flags_q[0] || (frag_off_q != 13'd0);
   assign ok_d       = (csum == 16'hFFFF) && !err_now && !(DROP_FRAG && fragmented);
   assign csum_en    = (state_d inside {HDR_1, HDR_2, HDR_3, HDR_4, HDR_5, OPTION});

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = HDR_1;
         HDR_1:   state_d = hdr_bad ? FIN : HDR_2;
         HDR_2:   state_d = HDR_3;
         HDR_3:   state_d = HDR_4;
         HDR_4:   state_d = HDR_5;
         HDR_5, OPTION: begin
            if (opt_cnt_q != 4'd0)      state_d = OPTION;
            else if (pay_cnt_q != '0)   state_d = PAYLOAD;
            else                        state_d = FIN;
         end
         PAYLOAD: if (pay_cnt_q == '0) state_d = FIN;
         FIN:     state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   ipv4_hdr_checksum u_csum (
      .clk_i  (clk),
      .rst_i  (reset),
      .en_i   (csum_en),
      .word_i (bus.data),
      .sum_o  (csum)
   );

   // Outputs are registered from the next state so each field lands the cycle after its word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         version_q       <= '0;
         ihl_q           <= '0;
         total_len_q     <= '0;
         ident_q         <= '0;
         flags_q         <= '0;
         frag_off_q      <= '0;
         ttl_q           <= '0;
         protocol_q      <= '0;
         src_ip_q        <= '0;
         dest_ip_q       <= '0;
         len_payload_q   <= '0;
         payload_data_q  <= '0;
         payload_valid_q <= 1'b0;
         payload_start_q <= 1'b0;
         hdr_err_q       <= 1'b0;
         fin_q           <= 1'b0;
         ok_q            <= 1'b0;
         opt_cnt_q       <= '0;
         pay_cnt_q       <= '0;
      end else begin
         state_q <= state_d;
         case (state_d)
            HDR_1: begin
               version_q   <= bus.data[31:28];
               ihl_q       <= bus.data[27:24];
               total_len_q <= bus.data[15:0];
               opt_cnt_q   <= bus.data[27:24] - IHL_MIN;
               pay_cnt_q   <= bus.data[15:0] - {10'd0, bus.data[27:24], 2'b00};
            end
            HDR_2: begin
               ident_q    <= bus.data[31:16];
               flags_q    <= bus.data[15:13];
               frag_off_q <= bus.data[12:0];
            end
            HDR_3: begin
               ttl_q      <= bus.data[31:24];
               protocol_q <= bus.data[23:16];
            end
            HDR_4:   src_ip_q  <= bus.data;
            HDR_5:   dest_ip_q <= bus.data;
            OPTION:  opt_cnt_q <= opt_cnt_q - 4'd1;
            // The last partial word is passed whole, so the counter saturates at zero.
            PAYLOAD: pay_cnt_q <= (pay_cnt_q > 16'd4) ? pay_cnt_q - 16'd4 : '0;
            FIN: begin
               fin_q         <= 1'b1;
               hdr_err_q     <= err_now;
               ok_q          <= ok_d;
               len_payload_q <= total_len_q - {10'd0, ihl_q, 2'b00};
            end
            default: ;
         endcase
         payload_valid_q <= (state_d == PAYLOAD);
         payload_data_q  <= (state_d == PAYLOAD) ? bus.data : '0;
         payload_start_q <= (state_d == PAYLOAD) && (state_q != PAYLOAD);
      end
   end

   assign bus.version       = version_q;
   assign bus.ihl           = ihl_q;
   assign bus.total_len     = total_len_q;
   assign bus.ident         = ident_q;
   assign bus.flags         = flags_q;
   assign bus.frag_off      = frag_off_q;
   assign bus.ttl           = ttl_q;
   assign bus.protocol      = protocol_q;
   assign bus.src_ip        = src_ip_q;
   assign bus.dest_ip       = dest_ip_q;
   assign bus.len_payload   = len_payload_q;
   assign bus.payload_data  = payload_data_q;
   assign bus.payload_valid = payload_valid_q;
   assign bus.payload_start = payload_start_q;
   assign bus.hdr_err       = hdr_err_q;
   assign bus.fin           = fin_q;
   assign bus.ok            = ok_q;

endmodule

// File: tb/tb_ipv4_decoder.sv
// Scoreboard bench for ipv4_decoder; a second instance runs with fragments allowed.
module tb_ipv4_decoder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ipv4_decoder_if b0 ();
   ipv4_decoder_if b1 ();
   assign b1.data  = b0.data;
   assign b1.start = b0.start;

   ipv4_decoder #(.DROP_FRAG(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   ipv4_decoder #(.DROP_FRAG(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

   int checks = 0;
   int errors = 0;
   logic [31:0] pkt[$];
   logic [31:0] exp_q[$];
   int n_valid, n_start, first_valid, fin_cyc;
   bit start_bad;

   function automatic logic [188:0] outs0();
      return {b0.version, b0.ihl, b0.total_len, b0.ident, b0.flags, b0.frag_off, b0.ttl,
              b0.protocol, b0.src_ip, b0.dest_ip, b0.len_payload, b0.payload_data,
              b0.payload_valid, b0.payload_start, b0.hdr_err, b0.fin, b0.ok};
   endfunction

   function automatic logic [188:0] outs1();
      return {b1.version, b1.ihl, b1.total_len, b1.ident, b1.flags, b1.frag_off, b1.ttl,
              b1.protocol, b1.src_ip, b1.dest_ip, b1.len_payload, b1.payload_data,
              b1.payload_valid, b1.payload_start, b1.hdr_err, b1.fin, b1.ok};
   endfunction

   // Standard IPv4 checksum over the first nw header words, written into word 2.
   task automatic fix_csum(input int nw);
      int unsigned s;
      logic [31:0] w;
      w = pkt[2]; w[15:0] = 16'h0; pkt[2] = w;
      s = 0;
      for (int i = 0; i < nw; i++) begin
         w = pkt[i];
         s = s + w[31:16] + w[15:0];
      end
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      w = pkt[2]; w[15:0] = ~s[15:0]; pkt[2] = w;
   endtask

   task automatic add_payload(input int n);
      for (int i = 0; i < n; i++) pkt.push_back($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1; b0.start = 1'b0; b0.data = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic drive_pkt(input int hdr_words, input int pay_words, input int rst_at);
      logic [31:0] e;
      n_valid = 0; n_start = 0; first_valid = -1; fin_cyc = -1; start_bad = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc < pkt.size()) begin
            b0.data = pkt[cyc];
            if (cyc >= hdr_words && cyc < hdr_words + pay_words) exp_q.push_back(pkt[cyc]);
         end else begin
            b0.data = '0;
         end
         b0.start = (cyc == 0);
         reset    = (cyc == rst_at);
         @(posedge clk); #1;
         if (reset) begin
            reset = 1'b0; b0.start = 1'b0;
            return;
         end
         if (b0.payload_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc + 1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL payload_extra got %h expected nothing", b0.payload_data);
            end else begin
               e = exp_q.pop_front();
               if (b0.payload_data !== e) begin
                  errors++;
                  $display("FAIL payload_data word %0d got %h expected %h", n_valid, b0.payload_data, e);
               end
            end
         end
         if (b0.payload_start) begin
            n_start++;
            if (!(b0.payload_valid && n_valid == 1)) start_bad = 1;
         end
         if (b0.fin && fin_cyc < 0) fin_cyc = cyc + 1;
         if (fin_cyc >= 0 && cyc >= pkt.size()) break;
      end
      checks++;
      if (fin_cyc < 0) begin
         errors++;
         $display("FAIL fin_timeout got fin=%b expected 1 within 200 cycles", b0.fin);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; b0.start = 1'b1; b0.data = 32'h45000073;
      @(posedge clk); #1;
      reset = 1'b0; b0.start = 1'b0; b0.data = 32'h00004000;
      @(posedge clk); #1;
      checks++;
      if (outs0() !== '0 || outs1() !== '0) begin
         errors++;
         $display("FAIL reset_state got %h expected 0", outs0());
      end
   endtask

   task automatic build_basic(input logic [31:0] w2, input logic [15:0] csum_fix);
      pkt = '{32'h45000073, w2, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
      fix_csum(5);
      if (csum_fix != 16'h0) pkt[2] = {16'h4011, csum_fix};
      add_payload(24);
   endtask

   task automatic test_basic();
      do_reset();
      pkt = '{32'h45000073, 32'h00004000, 32'h4011B861, 32'hC0A80001, 32'hC0A800C7};
      add_payload(24);
      drive_pkt(5, 24, -1);
      chk("basic_n_valid", n_valid, 24);
      chk("basic_n_start", n_start, 1);
      chk("basic_start_first", {31'd0, start_bad}, 0);
      chk("basic_first_valid", first_valid, 6);
      chk("basic_fin_cycle", fin_cyc, 30);
      chk("basic_len_payload", b0.len_payload, 95);
      chk("basic_protocol", b0.protocol, 17);
      chk("basic_fields", {b0.version, b0.ihl, b0.total_len, b0.ttl}, {4'd4, 4'd5, 16'h0073, 8'h40});
      chk("basic_addrs", b0.src_ip ^ b0.dest_ip, 32'hC0A80001 ^ 32'hC0A800C7);
      chk("basic_flags", {b0.flags, b0.frag_off}, 16'h4000);
      chk("basic_fin_ok", {b0.fin, b0.ok, b0.hdr_err, b0.payload_valid}, 4'b1100);
      chk("basic_data_cleared", b0.payload_data, 0);
      chk("basic_scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic test_bad_csum();
      do_reset();
      build_basic(32'h00004000, 16'hB862);
      drive_pkt(5, 24, -1);
      chk("badcs_n_valid", n_valid, 24);
      chk("badcs_fin_ok_err", {b0.fin, b0.ok, b0.hdr_err}, 3'b100);
   endtask

   task automatic test_option();
      do_reset();
      pkt = '{32'h46000038, 32'h00004000, 32'h40060000, 32'hC0A80001, 32'hC0A800C7,
              32'h01020304};
      fix_csum(6);
      add_payload(8);
      drive_pkt(6, 8, -1);
      chk("opt_first_valid", first_valid, 7);
      chk("opt_n_valid", n_valid, 8);
      chk("opt_len_payload", b0.len_payload, 32);
      chk("opt_protocol", b0.protocol, 6);
      chk("opt_fin_ok", {b0.fin, b0.ok, b0.hdr_err}, 3'b110);
   endtask

   task automatic test_hdr_err();
      do_reset();
      pkt = '{32'h35000014, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
      drive_pkt(5, 0, -1);
      chk("err_fin_cycle", fin_cyc, 2);
      chk("err_n_valid", n_valid, 0);
      chk("err_flags", {b0.fin, b0.ok, b0.hdr_err}, 3'b101);
   endtask

   task automatic test_frag();
      do_reset();
      build_basic(32'h00002000, 16'h0);
      drive_pkt(5, 24, -1);
      chk("frag_n_valid", n_valid, 24);
      chk("frag_drop_ok", {b0.fin, b0.ok}, 2'b10);
      chk("frag_keep_ok", {b1.fin, b1.ok}, 2'b11);
      chk("frag_flags", b0.flags, 3'b001);
   endtask

   task automatic test_no_payload();
      do_reset();
      pkt = '{32'h45000014, 32'h12340000, 32'h08010000, 32'h0A000001, 32'h0A000002};
      fix_csum(5);
      drive_pkt(5, 0, -1);
      chk("nopay_fin_cycle", fin_cyc, 6);
      chk("nopay_n_valid", n_valid, 0);
      chk("nopay_len", b0.len_payload, 0);
      chk("nopay_ok", {b0.fin, b0.ok, b0.ident}, {2'b11, 16'h1234});
   endtask

   task automatic test_mid_reset();
      do_reset();
      build_basic(32'h00004000, 16'h0);
      drive_pkt(5, 24, 7);
      checks++;
      if (outs0() !== '0 || outs1() !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got %h expected 0", outs0());
      end
      pkt.delete();
      pkt = '{32'h45000073, 32'hBEEF4000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
      fix_csum(5);
      add_payload(24);
      drive_pkt(5, 24, -1);
      chk("midreset_n_valid", n_valid, 24);
      chk("midreset_fresh", {b0.fin, b0.ok, b0.ident}, {2'b11, 16'hBEEF});
      chk("midreset_len", b0.len_payload, 95);
   endtask

   initial begin
      reset = 1'b1; b0.start = 1'b0; b0.data = '0;
      test_reset();
      test_basic();
      test_bad_csum();
      test_option();
      test_hdr_err();
      test_frag();
      test_no_payload();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
